// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: base opcodes,
// controller state encoding and the instruction-register reset value.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] RESET_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd7
  } ctrl_state_t;

  function automatic logic opc_is_legal(input logic [6:0] opc);
    logic legal;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: legal = 1'b1;
      default:                                 legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer: owns pc and the
// instruction register and drives the instruction/data memory handshakes.
module multicycle_controller
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clock,
  input  logic        Rst,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic        illegal
);

  ctrl_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instret_q, instret_d;
  logic        imem_req_q, imem_req_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic        rf_we_q, rf_we_d;
  logic        illegal_q, illegal_d;
  logic        retire;
  logic [6:0]  opcode;
  logic [31:0] seq_pc;

  assign opcode = ir_q[6:0];
  assign seq_pc = pc_q + PC_STEP;

  // Next-state, next-pc and handshake request logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    ir_d       = ir_q;
    instret_d  = instret_q;
    imem_req_d = imem_req_q;
    dmem_req_d = dmem_req_q;
    dmem_we_d  = dmem_we_q;
    rf_we_d    = 1'b0;
    illegal_d  = illegal_q;
    retire     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // An issued request is held until ack; stall only gates a new one.
        if (imem_req_q && imem_ack) begin
          ir_d       = imem_rdata;
          imem_req_d = 1'b0;
          state_d    = ST_DECODE;
        end else if (!imem_req_q && !stall) begin
          imem_req_d = 1'b1;
        end else begin
          imem_req_d = imem_req_q;
        end
      end
      ST_DECODE: begin
        if (opc_is_legal(opcode)) begin
          state_d = ST_EXECUTE;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end
      ST_EXECUTE: begin
        case (opcode)
          OPC_JAL, OPC_JALR: npc_d = branch_target;
          OPC_BRANCH:        npc_d = branch_taken ? branch_target : seq_pc;
          default:           npc_d = seq_pc;
        endcase
        case (opcode)
          OPC_LOAD, OPC_STORE: begin
            state_d    = ST_MEM;
            dmem_req_d = 1'b1;
            dmem_we_d  = (opcode == OPC_STORE);
          end
          OPC_BRANCH: retire = 1'b1;
          default: begin
            state_d = ST_WRITEBACK;
            rf_we_d = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (opcode == OPC_LOAD) begin
            state_d = ST_WRITEBACK;
            rf_we_d = 1'b1;
          end else begin
            retire = 1'b1;
          end
        end else begin
          dmem_req_d = 1'b1;
        end
      end
      ST_WRITEBACK: retire = 1'b1;
      ST_TRAP: begin
        imem_req_d = 1'b0;
        dmem_req_d = 1'b0;
        dmem_we_d  = 1'b0;
      end
      default: begin
        state_d    = ST_TRAP;
        imem_req_d = 1'b0;
        dmem_req_d = 1'b0;
        dmem_we_d  = 1'b0;
      end
    endcase

    // Retirement is the only place pc and instret advance.
    if (retire) begin
      pc_d       = npc_d;
      instret_d  = instret_q + 32'd1;
      state_d    = ST_FETCH;
      imem_req_d = !stall;
    end else begin
      pc_d = pc_q;
    end
  end

  // Controller state, pc, instruction register, requests and counters.
  always_ff @(posedge clock) begin
    if (Rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC;
      ir_q       <= RESET_NOP;
      instret_q  <= 32'd0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      ir_q       <= ir_d;
      instret_q  <= instret_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_we_q    <= rf_we_d;
      illegal_q  <= illegal_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign pc          = pc_q;
  assign instruction = ir_q;
  assign rf_we       = rf_we_q;
  assign state       = state_q;
  assign instret     = instret_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, hand-written
// corner sequences and randomized instruction streams against an instruction-level model.
module tb_multicycle_controller;

  logic        clock = 1'b0;
  logic        Rst, stall, imem_ack, dmem_ack, branch_taken;
  logic [31:0] imem_rdata, branch_target;
  logic        imem_req, dmem_req, dmem_we, rf_we, illegal;
  logic [31:0] imem_addr, pc, instruction, instret;
  logic [2:0]  state;

  multicycle_controller dut (
    .clock(clock), .Rst(Rst), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .instruction(instruction), .rf_we(rf_we), .state(state),
    .instret(instret), .illegal(illegal)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] m_pc      = 32'd0;
  logic [31:0] m_instret = 32'd0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] target;
    int          ddly;
    int          cycles;
    int          rf;
  } vec_t;

  vec_t vecs[14];
  logic [6:0] opcs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic is_load(input logic [6:0] o);   return o == 7'h03; endfunction
  function automatic logic is_store(input logic [6:0] o);  return o == 7'h23; endfunction
  function automatic logic is_branch(input logic [6:0] o); return o == 7'h63; endfunction
  function automatic logic is_jump(input logic [6:0] o);   return (o == 7'h6F) || (o == 7'h67); endfunction

  function automatic int ref_cycles(input logic [6:0] o, input int ddly);
    if (is_load(o)) return 5 + ddly;
    if (is_store(o)) return 4 + ddly;
    if (is_branch(o)) return 3;
    return 4;
  endfunction

  function automatic int ref_rf(input logic [6:0] o);
    return (is_branch(o) || is_store(o)) ? 0 : 1;
  endfunction

  function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [6:0] o,
                                               input logic tk, input logic [31:0] tgt);
    if (is_jump(o) || (is_branch(o) && tk)) return tgt;
    return cur + 32'd1;
  endfunction

  // Waits (bounded) for a fetch request, optionally delays, then acks with instr.
  task automatic fetch_word(input logic [31:0] instr, input int dly, output logic [31:0] addr);
    int g;
    g = 0;
    while (imem_req !== 1'b1 && g < 50) begin
      @(negedge clock);
      g++;
    end
    chk("imem_req_seen", {31'd0, imem_req}, 32'd1);
    addr = imem_addr;
    repeat (dly) @(negedge clock);
    chk("imem_req_held", {31'd0, imem_req}, 32'd1);
    imem_rdata = instr;
    imem_ack   = 1'b1;
    @(negedge clock);
    imem_ack   = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] instr, input logic tk, input logic [31:0] tgt,
                           input int idly, input int ddly,
                           output int cycles, output int rf_cnt, output int dreq_cnt,
                           output logic dwe, output logic both, output logic [31:0] addr);
    branch_taken  = tk;
    branch_target = tgt;
    fetch_word(instr, idly, addr);
    cycles = 1; rf_cnt = 0; dreq_cnt = 0; dwe = 1'b0; both = 1'b0;
    for (int g = 0; g < 60; g++) begin
      if (rf_we) rf_cnt++;
      if (imem_req && dmem_req) both = 1'b1;
      if (dmem_req) begin
        dreq_cnt++;
        dwe      = dmem_we;
        dmem_ack = (dreq_cnt == ddly + 1);
      end else begin
        dmem_ack = 1'b0;
      end
      if (state == 3'd0) break;
      @(negedge clock);
      cycles++;
    end
    dmem_ack = 1'b0;
  endtask

  task automatic do_instr(input string name, input logic [31:0] instr, input logic tk,
                          input logic [31:0] tgt, input int idly, input int ddly,
                          input int exp_cyc, input int exp_rf);
    int cyc, rfc, drq;
    logic dwe, both;
    logic [31:0] addr;
    logic [6:0] o;
    o = instr[6:0];
    run_instr(instr, tk, tgt, idly, ddly, cyc, rfc, drq, dwe, both, addr);
    chk({name, " fetch_addr"}, addr, m_pc);
    chk({name, " cycles"}, cyc, exp_cyc);
    chk({name, " rf_we_pulses"}, rfc, exp_rf);
    chk({name, " dmem_req_cycles"}, drq, (is_load(o) || is_store(o)) ? ddly + 1 : 0);
    if (is_load(o) || is_store(o)) chk({name, " dmem_we"}, {31'd0, dwe}, {31'd0, is_store(o)});
    chk({name, " req_overlap"}, {31'd0, both}, 32'd0);
    m_pc      = ref_next_pc(m_pc, o, tk, tgt);
    m_instret = m_instret + 32'd1;
    chk({name, " pc"}, pc, m_pc);
    chk({name, " instret"}, instret, m_instret);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, r;
    vecs[0]  = '{"op",        32'h002081B3, 1'b0, 32'h0,         0, 4, 1};
    vecs[1]  = '{"load_d3",   32'h0000A103, 1'b0, 32'h0,         3, 8, 1};
    vecs[2]  = '{"load_d0",   32'h0000A103, 1'b0, 32'h0,         0, 5, 1};
    vecs[3]  = '{"store_d0",  32'h0020A023, 1'b0, 32'h0,         0, 4, 0};
    vecs[4]  = '{"store_d2",  32'h0020A023, 1'b0, 32'h0,         2, 6, 0};
    vecs[5]  = '{"br_taken",  32'h00208463, 1'b1, 32'h40,        0, 3, 0};
    vecs[6]  = '{"br_not",    32'h00208463, 1'b0, 32'h80,        0, 3, 0};
    vecs[7]  = '{"jal",       32'h0080006F, 1'b0, 32'h100,       0, 4, 1};
    vecs[8]  = '{"jalr",      32'h00008067, 1'b1, 32'h200,       0, 4, 1};
    vecs[9]  = '{"lui",       32'h123450B7, 1'b1, 32'h999,       0, 4, 1};
    vecs[10] = '{"auipc",     32'h00001097, 1'b0, 32'h0,         0, 4, 1};
    vecs[11] = '{"op_imm",    32'h00100093, 1'b0, 32'h0,         0, 4, 1};
    vecs[12] = '{"jal_top",   32'h0080006F, 1'b0, 32'hFFFF_FFFF, 0, 4, 1};
    vecs[13] = '{"op_wrap",   32'h002081B3, 1'b0, 32'h0,         0, 4, 1};
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    Rst = 1'b1; stall = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    branch_taken = 1'b0; imem_rdata = 32'h0; branch_target = 32'h0;
    repeat (3) @(negedge clock);
    chk("rst state", {29'd0, state}, 32'd0);
    chk("rst pc", pc, 32'd0);
    chk("rst instruction", instruction, 32'h0000_0013);
    chk("rst imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst dmem_we", {31'd0, dmem_we}, 32'd0);
    chk("rst rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst instret", instret, 32'd0);
    chk("rst illegal", {31'd0, illegal}, 32'd0);
    Rst = 1'b0;
    @(negedge clock);
    chk("first imem_req", {31'd0, imem_req}, 32'd1);

    for (int i = 0; i < 14; i++)
      do_instr(vecs[i].name, vecs[i].instr, vecs[i].taken, vecs[i].target, 0,
               vecs[i].ddly, vecs[i].cycles, vecs[i].rf);

    // Stall raised after the request is out: request must survive until ack.
    stall = 1'b1;
    repeat (3) @(negedge clock);
    chk("stall keeps req", {31'd0, imem_req}, 32'd1);
    do_instr("op_stalled", 32'h002081B3, 1'b0, 32'h0, 1, 0, 4, 1);
    chk("stall blocks new req", {31'd0, imem_req}, 32'd0);
    repeat (3) @(negedge clock);
    chk("stall still blocked", {31'd0, imem_req}, 32'd0);
    chk("stall pc steady", pc, m_pc);
    stall = 1'b0;
    @(negedge clock);
    chk("unstall req", {31'd0, imem_req}, 32'd1);

    // Unknown opcode traps and freezes everything until reset.
    fetch_word(32'h0000007F, 0, a);
    chk("ill decode state", {29'd0, state}, 32'd1);
    @(negedge clock);
    chk("ill trap state", {29'd0, state}, 32'd7);
    chk("ill flag", {31'd0, illegal}, 32'd1);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (4) @(negedge clock);
    chk("trap sticky", {29'd0, state}, 32'd7);
    chk("trap imem_req", {31'd0, imem_req}, 32'd0);
    chk("trap dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("trap rf_we", {31'd0, rf_we}, 32'd0);
    chk("trap pc", pc, m_pc);
    chk("trap instret", instret, m_instret);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    Rst = 1'b1;
    @(negedge clock);
    Rst = 1'b0;
    m_pc = 32'd0; m_instret = 32'd0;
    chk("trap rst pc", pc, 32'd0);
    chk("trap rst illegal", {31'd0, illegal}, 32'd0);
    chk("trap rst state", {29'd0, state}, 32'd0);
    chk("trap rst instret", instret, 32'd0);

    // Reset in the middle of a data access abandons it.
    fetch_word(32'h0020A023, 0, a);
    @(negedge clock);
    @(negedge clock);
    chk("mem state", {29'd0, state}, 32'd3);
    chk("mem req", {31'd0, dmem_req}, 32'd1);
    chk("mem we", {31'd0, dmem_we}, 32'd1);
    @(negedge clock);
    Rst = 1'b1;
    @(negedge clock);
    Rst = 1'b0;
    chk("midmem rst dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("midmem rst state", {29'd0, state}, 32'd0);
    chk("midmem rst imem_req", {31'd0, imem_req}, 32'd0);
    @(negedge clock);
    chk("midmem first req", {31'd0, imem_req}, 32'd1);

    // Randomized instruction stream with random memory wait states.
    for (int n = 0; n < 40; n++) begin
      logic [6:0] o;
      logic [31:0] ins;
      logic tk;
      int id, dd;
      r   = $urandom();
      o   = opcs[$urandom_range(0, 8)];
      ins = {r[31:7], o};
      tk  = 1'($urandom_range(0, 1));
      a   = $urandom();
      id  = $urandom_range(0, 3);
      dd  = $urandom_range(0, 3);
      do_instr("rand", ins, tk, a, id, dd, ref_cycles(o, dd), ref_rf(o));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
